// File: rtl/gecko_writeback_pkg.sv
// rtl/gecko_writeback_pkg.sv - shared types, load funct3 codes and source ids for the writeback stage
package gecko_writeback_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0] rd_addr;
    logic [2:0] funct3;
    logic [1:0] offset;
  } gecko_load_command_t;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_value;
  } gecko_reg_result_t;

  typedef enum logic [1:0] {
    SRC_LOAD = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_CSR  = 2'd2
  } wb_src_e;

  // Round-robin successor in the order load -> ALU -> CSR -> load.
  function automatic wb_src_e next_src(wb_src_e s);
    case (s)
      SRC_LOAD: next_src = SRC_ALU;
      SRC_ALU:  next_src = SRC_CSR;
      default:  next_src = SRC_LOAD;
    endcase
  endfunction

endpackage

// File: rtl/gecko_writeback_if.sv
// rtl/gecko_writeback_if.sv - valid/ready stream and memory-result interfaces with modports
interface std_stream_intf #(parameter int WIDTH = 37);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport in     (input valid, input data, output ready);
  modport out    (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
  modport master (output valid, output data, input ready);
endinterface

interface std_mem_intf #(parameter int WIDTH = 32);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport in     (input valid, input data, output ready);
  modport out    (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
  modport master (output valid, output data, input ready);
endinterface

// File: rtl/gecko_writeback_fifo.sv
// rtl/gecko_writeback_fifo.sv - std_fifo, synchronous FIFO holding outstanding load commands
module std_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end
endmodule

// File: rtl/gecko_writeback.sv
// rtl/gecko_writeback.sv - load alignment plus load/ALU/CSR writeback arbiter
// Optional round-robin arbitration: define GECKO_WRITEBACK_ROUND_ROBIN_EN (default fixed priority).
module gecko_writeback
  import gecko_writeback_pkg::*;
#(
  parameter int LOAD_QUEUE_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  std_stream_intf.in        load_command_in,
  std_mem_intf.in           data_result_in,
  std_stream_intf.in        alu_result_in,
  std_stream_intf.in        csr_result_in,
  output logic              register_writeback_valid,
  output gecko_reg_result_t register_writeback_out,
  output logic              load_queue_empty
);
  gecko_load_command_t push_cmd, head;
  logic                fifo_full, fifo_empty;
  logic                load_cand, alu_cand, csr_cand, grant;
  wb_src_e             winner;
  logic [31:0]         word, load_value;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  gecko_reg_result_t   win_result;
  logic                wb_valid_q, wb_valid_d;
  gecko_reg_result_t   wb_out_q, wb_out_d;

  assign push_cmd              = load_command_in.data[$bits(gecko_load_command_t)-1:0];
  assign load_command_in.ready = !fifo_full && !rst;

  std_fifo #(
    .WIDTH($bits(gecko_load_command_t)),
    .DEPTH(LOAD_QUEUE_DEPTH)
  ) u_load_queue (
    .clk        (clk),
    .rst        (rst),
    .push_i     (load_command_in.valid && load_command_in.ready),
    .push_data_i(push_cmd),
    .pop_i      (data_result_in.ready),
    .pop_data_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign load_queue_empty = fifo_empty;
  assign word             = data_result_in.data;
  assign half_sel         = head.offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (head.offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    case (head.funct3)
      FUNCT3_LB:  load_value = {{24{byte_sel[7]}}, byte_sel};
      FUNCT3_LH:  load_value = {{16{half_sel[15]}}, half_sel};
      FUNCT3_LBU: load_value = {24'd0, byte_sel};
      FUNCT3_LHU: load_value = {16'd0, half_sel};
      default:    load_value = word;
    endcase
  end

  // A result can only pair with a command already sitting in the queue.
  assign load_cand = data_result_in.valid && !fifo_empty && !rst;
  assign alu_cand  = alu_result_in.valid && !rst;
  assign csr_cand  = csr_result_in.valid && !rst;
  assign grant     = load_cand || alu_cand || csr_cand;

`ifdef GECKO_WRITEBACK_ROUND_ROBIN_EN
  wb_src_e rr_q, rr_d;

  assign rr_d = grant ? next_src(winner) : rr_q;

  always_ff @(posedge clk) begin
    if (rst) rr_q <= SRC_LOAD;
    else     rr_q <= rr_d;
  end
`endif

  always_comb begin
    winner = SRC_LOAD;
`ifdef GECKO_WRITEBACK_ROUND_ROBIN_EN
    case (rr_q)
      SRC_ALU: begin
        if (alu_cand)       winner = SRC_ALU;
        else if (csr_cand)  winner = SRC_CSR;
        else                winner = SRC_LOAD;
      end
      SRC_CSR: begin
        if (csr_cand)       winner = SRC_CSR;
        else if (load_cand) winner = SRC_LOAD;
        else if (alu_cand)  winner = SRC_ALU;
      end
      default: begin
        if (load_cand)      winner = SRC_LOAD;
        else if (alu_cand)  winner = SRC_ALU;
        else if (csr_cand)  winner = SRC_CSR;
      end
    endcase
`else
    if (load_cand)      winner = SRC_LOAD;
    else if (alu_cand)  winner = SRC_ALU;
    else if (csr_cand)  winner = SRC_CSR;
`endif
  end

  assign data_result_in.ready = grant && (winner == SRC_LOAD);
  assign alu_result_in.ready  = grant && (winner == SRC_ALU);
  assign csr_result_in.ready  = grant && (winner == SRC_CSR);

  always_comb begin
    case (winner)
      SRC_ALU: win_result = alu_result_in.data;
      SRC_CSR: win_result = csr_result_in.data;
      default: win_result = '{rd_addr: head.rd_addr, rd_value: load_value};
    endcase
    // Writes to x0 are consumed silently.
    wb_valid_d = grant && (win_result.rd_addr != 5'd0);
    wb_out_d   = wb_valid_d ? win_result : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_out_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_out_q   <= wb_out_d;
    end
  end

  assign register_writeback_valid = wb_valid_q;
  assign register_writeback_out   = wb_out_q;
endmodule
